// File: rtl/framebuffer_window_writer.sv
// Framebuffer write-address generator for the DBI/DCS command stream.
// Decodes CASET/PASET windows and RAMWR/RAMWR-continue pixel streams.
//
// Ports:
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_command(_latch)     DCS command byte and its strobe
//   i_param(_latch)       command parameter byte and its strobe
//   i_pixel(_latch)       assembled pixel and its strobe
//   o_write_address/data  framebuffer write port, 1-cycle latency
//   o_write_enable        write strobe
//   o_window_done         pulse with the last pixel of the window
//   o_pixel_count         pixels written since 2Ch (FB_WRITER_PIXCNT_EN)
//
// Optional build macro: FB_WRITER_PIXCNT_EN adds the pixel counter.

module framebuffer_window_writer #(
   parameter int H_RES  = 320,
   parameter int V_RES  = 240,
   parameter int ADDR_W = 18,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic [7:0]        i_command,
   input  logic              i_command_latch,
   input  logic [7:0]        i_param,
   input  logic              i_param_latch,
   input  logic [DATA_W-1:0] i_pixel,
   input  logic              i_pixel_latch,
   output logic [ADDR_W-1:0] o_write_address,
   output logic [DATA_W-1:0] o_write_data,
   output logic              o_write_enable,
   output logic              o_window_done
`ifdef FB_WRITER_PIXCNT_EN
   ,
   output logic [ADDR_W-1:0] o_pixel_count
`endif
);

   localparam logic [15:0]       X_MAX = 16'(H_RES - 1);
   localparam logic [15:0]       Y_MAX = 16'(V_RES - 1);
   localparam logic [ADDR_W-1:0] PITCH = ADDR_W'(H_RES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CASET,
      S_PASET,
      S_RAMWR
   } state_t;

   state_t            state;
   logic [2:0]        p_idx;
   logic [15:0]       p_start;
   logic [7:0]        p_end_hi;
   logic [15:0]       sc, ec, sp, ep;
   logic [15:0]       cur_x, cur_y;
   logic [ADDR_W-1:0] cur_addr;

   logic              param_ok;
   logic              pix_ok;
   logic              at_ex, at_ey;
   logic [15:0]       p_end, lim;
   logic [15:0]       c_start, c_end_clip, c_end;
   logic [ADDR_W-1:0] origin, row_step;

   // Command strobe always wins over a coincident data strobe.
   assign param_ok = i_param_latch && !i_command_latch &&
                     (state == S_CASET || state == S_PASET) &&
                     (p_idx < 3'd4);
   assign pix_ok   = i_pixel_latch && !i_command_latch &&
                     (state == S_RAMWR);

   // >= rather than == keeps the cursor inside the window even if
   // 3Ch resumes after the window shrank under it.
   assign at_ex = (cur_x >= ec);
   assign at_ey = (cur_y >= ep);

   assign origin   = ADDR_W'(sp) * PITCH + ADDR_W'(sc);
   assign row_step = PITCH - ADDR_W'(ec - sc);

   // Clamp the pending window on the 4th parameter byte.
   always_comb begin
      p_end      = {p_end_hi, i_param};
      lim        = (state == S_CASET) ? X_MAX : Y_MAX;
      c_start    = (p_start > lim) ? lim : p_start;
      c_end_clip = (p_end > lim) ? lim : p_end;
      c_end      = (c_start > c_end_clip) ? c_start : c_end_clip;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state           <= S_IDLE;
         p_idx           <= '0;
         p_start         <= '0;
         p_end_hi        <= '0;
         sc              <= '0;
         ec              <= X_MAX;
         sp              <= '0;
         ep              <= Y_MAX;
         cur_x           <= '0;
         cur_y           <= '0;
         cur_addr        <= '0;
         o_write_address <= '0;
         o_write_data    <= '0;
         o_write_enable  <= 1'b0;
         o_window_done   <= 1'b0;
      end else begin
         o_write_enable <= pix_ok;
         o_window_done  <= pix_ok && at_ex && at_ey;

         if (pix_ok) begin
            o_write_data    <= i_pixel;
            o_write_address <= cur_addr;
            if (!at_ex) begin
               cur_x    <= cur_x + 16'd1;
               cur_addr <= cur_addr + 1'b1;
            end else if (!at_ey) begin
               cur_x    <= sc;
               cur_y    <= cur_y + 16'd1;
               cur_addr <= cur_addr + row_step;
            end else begin
               cur_x    <= sc;
               cur_y    <= sp;
               cur_addr <= origin;
            end
         end

         if (i_command_latch) begin
            case (i_command)
               8'h2A: begin
                  state <= S_CASET;
                  p_idx <= '0;
               end
               8'h2B: begin
                  state <= S_PASET;
                  p_idx <= '0;
               end
               8'h2C: begin
                  state    <= S_RAMWR;
                  cur_x    <= sc;
                  cur_y    <= sp;
                  cur_addr <= origin;
               end
               8'h3C:   state <= S_RAMWR;
               default: state <= S_IDLE;
            endcase
         end else if (param_ok) begin
            p_idx <= p_idx + 3'd1;
            case (p_idx)
               3'd0: p_start[15:8] <= i_param;
               3'd1: p_start[7:0]  <= i_param;
               3'd2: p_end_hi      <= i_param;
               3'd3: begin
                  if (state == S_CASET) begin
                     sc <= c_start;
                     ec <= c_end;
                  end else begin
                     sp <= c_start;
                     ep <= c_end;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef FB_WRITER_PIXCNT_EN
   // Counts with the accepted pixel so it steps alongside its write.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_pixel_count <= '0;
      end else if (i_command_latch && i_command == 8'h2C) begin
         o_pixel_count <= '0;
      end else if (pix_ok && !(&o_pixel_count)) begin
         o_pixel_count <= o_pixel_count + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_framebuffer_window_writer.sv
// Scoreboard bench for framebuffer_window_writer.
// Directed command/param/pixel vectors with hand-computed writes.

module tb_framebuffer_window_writer;

   logic        clk;
   logic        rst_n;
   logic [7:0]  i_command;
   logic        i_command_latch;
   logic [7:0]  i_param;
   logic        i_param_latch;
   logic [15:0] i_pixel;
   logic        i_pixel_latch;
   logic [17:0] o_write_address;
   logic [15:0] o_write_data;
   logic        o_write_enable;
   logic        o_window_done;
`ifdef FB_WRITER_PIXCNT_EN
   logic [17:0] o_pixel_count;
`endif

   framebuffer_window_writer dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_command       (i_command),
      .i_command_latch (i_command_latch),
      .i_param         (i_param),
      .i_param_latch   (i_param_latch),
      .i_pixel         (i_pixel),
      .i_pixel_latch   (i_pixel_latch),
      .o_write_address (o_write_address),
      .o_write_data    (o_write_data),
      .o_write_enable  (o_write_enable),
      .o_window_done   (o_window_done)
`ifdef FB_WRITER_PIXCNT_EN
      ,
      .o_pixel_count   (o_pixel_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [17:0] addr;
      logic [15:0] data;
      logic        done;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: pop one expectation per observed write.
   exp_t e;
   always @(negedge clk) begin
      if (o_write_enable) begin
         if (q.size() == 0) begin
            chk("unexpected_write", {14'd0, o_write_address}, 32'hFFFFFFFF);
         end else begin
            e = q.pop_front();
            chk("write_latency", cyc, e.cyc);
            chk("write_address", {14'd0, o_write_address}, {14'd0, e.addr});
            chk("write_data", {16'd0, o_write_data}, {16'd0, e.data});
            chk("window_done", {31'd0, o_window_done}, {31'd0, e.done});
         end
      end else if (o_window_done) begin
         chk("done_without_write", 32'd1, 32'd0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [7:0] c);
      i_command       = c;
      i_command_latch = 1'b1;
      tick();
      i_command_latch = 1'b0;
   endtask

   task automatic par(input logic [7:0] b);
      i_param       = b;
      i_param_latch = 1'b1;
      tick();
      i_param_latch = 1'b0;
   endtask

   task automatic win(input logic [7:0] c, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3);
      cmd(c);
      par(b0);
      par(b1);
      par(b2);
      par(b3);
   endtask

   // Accepted pixel: expect a write at the sampling edge's cycle.
   task automatic pix(input logic [15:0] d, input int a, input bit dn);
      exp_t x;
      i_pixel       = d;
      i_pixel_latch = 1'b1;
      tick();
      i_pixel_latch = 1'b0;
      x.cyc  = cyc;
      x.addr = 18'(a);
      x.data = d;
      x.done = dn;
      q.push_back(x);
   endtask

   task automatic pix_drop(input logic [15:0] d);
      i_pixel       = d;
      i_pixel_latch = 1'b1;
      tick();
      i_pixel_latch = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      @(negedge clk);
      chk({tag, "_we"}, {31'd0, o_write_enable}, 32'd0);
      chk({tag, "_addr"}, {14'd0, o_write_address}, 32'd0);
      chk({tag, "_data"}, {16'd0, o_write_data}, 32'd0);
      chk({tag, "_done"}, {31'd0, o_window_done}, 32'd0);
`ifdef FB_WRITER_PIXCNT_EN
      chk({tag, "_count"}, {14'd0, o_pixel_count}, 32'd0);
`endif
   endtask

   initial begin
      rst_n           = 1'b0;
      i_command       = '0;
      i_command_latch = 1'b0;
      i_param         = '0;
      i_param_latch   = 1'b0;
      i_pixel         = '0;
      i_pixel_latch   = 1'b0;
      repeat (3) @(posedge clk);
      chk_zero("reset");
      tick();
      rst_n = 1'b1;

      // Full-screen linear writes from reset window.
      cmd(8'h2C);
      pix(16'h00A1, 0, 0);
      pix(16'h00A2, 1, 0);
      pix(16'h00A3, 2, 0);

      // 3x2 window at (10,5) with row and window wrap.
      win(8'h2A, 8'h00, 8'h0A, 8'h00, 8'h0C);
      win(8'h2B, 8'h00, 8'h05, 8'h00, 8'h06);
      cmd(8'h2C);
      pix(16'h1001, 1610, 0);
      pix(16'h1002, 1611, 0);
      pix(16'h1003, 1612, 0);
      pix(16'h1004, 1930, 0);
      pix(16'h1005, 1931, 0);
      pix(16'h1006, 1932, 1);
      pix(16'h1007, 1610, 0);

      // Out-of-range columns clamp to 319.
      win(8'h2A, 8'h01, 8'hF4, 8'h01, 8'hFF);
      win(8'h2B, 8'h00, 8'h00, 8'h00, 8'hEF);
      cmd(8'h2C);
      pix(16'h2001, 319, 0);
      pix(16'h2002, 639, 0);

      // Rows 2..3, then an incomplete CASET keeps SC=EC=319.
      win(8'h2B, 8'h00, 8'h02, 8'h00, 8'h03);
      cmd(8'h2A);
      par(8'h00);
      par(8'h05);
      par(8'h00);
      cmd(8'h2C);
      pix(16'h3001, 959, 0);
      pix(16'h3002, 1279, 1);

      // Non-window command stops RAMWR; 3Ch resumes.
      win(8'h2A, 8'h00, 8'h00, 8'h01, 8'h3F);
      win(8'h2B, 8'h00, 8'h00, 8'h00, 8'hEF);
      cmd(8'h2C);
      pix(16'h4001, 0, 0);
      pix(16'h4002, 1, 0);
      cmd(8'h00);
      pix_drop(16'h4BAD);
      cmd(8'h3C);
      pix(16'h4003, 2, 0);

      // Extra CASET params ignored; one-row window x=1..2.
      cmd(8'h2A);
      par(8'h00);
      par(8'h01);
      par(8'h00);
      par(8'h02);
      par(8'h00);
      par(8'h09);
      win(8'h2B, 8'h00, 8'h00, 8'h00, 8'h00);
      cmd(8'h2C);
      pix(16'h5001, 1, 0);
      pix(16'h5002, 2, 1);
      pix(16'h5003, 1, 0);

      // start > end forces a single-pixel window at (20,1).
      win(8'h2A, 8'h00, 8'h14, 8'h00, 8'h0A);
      win(8'h2B, 8'h00, 8'h01, 8'h00, 8'h00);
      cmd(8'h2C);
      pix(16'h6001, 340, 1);
      pix(16'h6002, 340, 1);

      // Params in IDLE/RAMWR and pixels in IDLE are ignored.
      cmd(8'h00);
      par(8'hFF);
      par(8'hFF);
      pix_drop(16'h6BAD);
      cmd(8'h2C);
      par(8'h00);
      pix(16'h6003, 340, 1);

      // Command wins over a coincident pixel strobe.
      win(8'h2A, 8'h00, 8'h00, 8'h01, 8'h3F);
      win(8'h2B, 8'h00, 8'h00, 8'h00, 8'hEF);
      cmd(8'h2C);
      pix(16'h7001, 0, 0);
      pix(16'h7002, 1, 0);
      i_command       = 8'h2C;
      i_command_latch = 1'b1;
      i_pixel         = 16'h7BAD;
      i_pixel_latch   = 1'b1;
      tick();
      i_command_latch = 1'b0;
      i_pixel_latch   = 1'b0;
      pix(16'h7003, 0, 0);
`ifdef FB_WRITER_PIXCNT_EN
      @(negedge clk);
      chk("pixel_count", {14'd0, o_pixel_count}, 32'd1);
      tick();
`endif

      // Reset mid-stream suppresses the pending write and the window.
      win(8'h2A, 8'h00, 8'h05, 8'h00, 8'h09);
      cmd(8'h2C);
      pix(16'h8001, 5, 0);
      i_pixel       = 16'h8BAD;
      i_pixel_latch = 1'b1;
      rst_n         = 1'b0;
      tick();
      i_pixel_latch = 1'b0;
      chk_zero("midreset");
      tick();
      rst_n = 1'b1;
      cmd(8'h2C);
      pix(16'h8002, 0, 0);
      pix(16'h8003, 1, 0);

      repeat (4) tick();
      chk("queue_drained", q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
